// File: rtl/pc_fetch.sv
// Program counter register and instruction-fetch sequencer.
// Holds the PC. Fetches the word at the PC over a req/gnt/rvalid handshake,
// presents it to decode, and loads npc_addr when the core retires the instruction.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      npc_addr,
  input  logic             advance,
  output logic [31:0]      pc_addr,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst,
  output logic             inst_valid,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

  // State and datapath registers; synchronous reset has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  // Next-state and next-datapath decode; inputs outside their state are ignored.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    misalign_d   = misalign_q;
    fetch_cnt_d  = fetch_cnt_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          inst_d       = imem_rdata;
          fetch_cnt_d  = fetch_cnt_q + CNT_W'(1);
          inst_valid_d = 1'b1;
          state_d      = S_VALID;
        end
      end
      S_VALID: begin
        if (advance) begin
          pc_d         = npc_addr;
          inst_valid_d = 1'b0;
          if (npc_addr[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = S_ERR;
          end else begin
            state_d    = S_REQ;
          end
        end
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Request is decoded from state so the address is stable while the request waits for gnt.
  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = pc_q;

  assign pc_addr    = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign misalign   = misalign_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_pc_fetch;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      npc_addr;
  logic             advance;
  logic [31:0]      pc_addr;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic [31:0]      inst;
  logic             inst_valid;
  logic             misalign;
  logic [CNT_W-1:0] fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a fetch is "started" after the idle cycle, "granted" while
  // awaiting data, "holding" an instruction, or "halted" after a misaligned retire.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_holding;
  logic        m_mis;
  int          m_cnt;
  logic        m_started;
  logic        m_granted;
  logic        m_halted;

  pc_fetch #(.RESET_PC(32'h0000_3000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .npc_addr(npc_addr), .advance(advance),
    .pc_addr(pc_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .misalign(misalign), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic adv, input logic [31:0] npc,
                            input logic gnt, input logic rv, input logic [31:0] rd);
    if (r) begin
      m_pc = 32'h3000; m_inst = 32'h0; m_holding = 1'b0; m_mis = 1'b0; m_cnt = 0;
      m_started = 1'b0; m_granted = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      // nothing changes until reset
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_holding) begin
      if (adv) begin
        m_pc = npc;
        m_holding = 1'b0;
        if (npc % 4 != 0) begin
          m_mis = 1'b1;
          m_halted = 1'b1;
        end
      end
    end else if (m_granted) begin
      if (rv) begin
        m_inst = rd;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_holding = 1'b1;
        m_granted = 1'b0;
      end
    end else if (gnt) begin
      m_granted = 1'b1;
    end
  endtask

  task automatic check_all();
    logic exp_req;
    exp_req = m_started && !m_granted && !m_holding && !m_halted;
    chk("pc_addr", pc_addr, m_pc);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("inst", inst, m_inst);
    chk("inst_valid", 32'(inst_valid), 32'(m_holding));
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare after the edge.
  task automatic step(input logic r, input logic adv, input logic [31:0] npc,
                      input logic gnt, input logic rv, input logic [31:0] rd);
    rst = r; advance = adv; npc_addr = npc; imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
    @(posedge clk);
    model_edge(r, adv, npc, gnt, rv, rd);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] held_addr;
    rst = 1'b1; advance = 1'b0; npc_addr = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    m_started = 1'b0;

    // Reset state with hostile inputs.
    step(1, 1, 32'h1234_5678, 1, 1, 32'hdead_beef);
    step(1, 0, 32'h0, 0, 0, 32'h0);
    chk("reset_pc", pc_addr, 32'h3000);
    chk("reset_req", 32'(imem_req), 32'd0);

    // Immediate gnt and rvalid from reset release.
    step(0, 0, 32'h0, 0, 0, 32'h0);             // idle cycle -> request
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h3000);
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h2408_0005);
    chk("t1_valid", 32'(inst_valid), 32'd1);
    chk("t1_inst", inst, 32'h2408_0005);

    // Retire to 3004, then gnt held off 4 cycles and rvalid delayed 3 cycles.
    step(0, 1, 32'h3004, 0, 0, 32'h0);
    held_addr = imem_addr;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t2_addr_stable", imem_addr, held_addr);
    end
    step(0, 0, 32'h0, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 0, 32'h1111_1111);
    step(0, 0, 32'h0, 0, 1, 32'h8c09_0000);
    chk("t2_count", 32'(fetch_cnt), 32'd2);

    // Branch retire to 3040: inst_valid low for two cycles.
    step(0, 1, 32'h3040, 0, 0, 32'h0);
    chk("t3_addr", imem_addr, 32'h3040);
    step(0, 0, 32'h0, 1, 0, 32'h0);
    chk("t3_gap", 32'(inst_valid), 32'd0);
    step(0, 0, 32'h0, 0, 1, 32'h1000_ffff);
    chk("t3_valid", 32'(inst_valid), 32'd1);

    // Spurious rvalid in REQ, advance during WAIT, reset mid-fetch.
    step(0, 1, 32'h3044, 0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'hbad0_0001);
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 1, 32'h5000, 0, 0, 32'h0);
    chk("t5_pc_hold", pc_addr, 32'h3044);
    step(1, 0, 32'h0, 0, 0, 32'h0);
    chk("t5_rst_pc", pc_addr, 32'h3000);
    step(0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h0000_000c);
    step(0, 0, 32'h0, 1, 1, 32'hbad0_0002); // spurious rvalid while holding
    chk("t5_inst_hold", inst, 32'h0000_000c);

    // Misaligned retire: sticky flag, no further requests.
    step(0, 1, 32'h3006, 0, 0, 32'h0);
    chk("t4_mis", 32'(misalign), 32'd1);
    chk("t4_pc", pc_addr, 32'h3006);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h3008, 1, 1, 32'h0);
    chk("t4_no_req", 32'(imem_req), 32'd0);

    // Seventeen fetches from reset: a 4-bit counter wraps to 1.
    step(1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 32'h0, 1, 0, 32'h0);
      step(0, 0, 32'h0, 0, 1, 32'(i));
      step(0, 1, 32'h3000 + 32'(4 * (i + 1)), 0, 0, 32'h0);
    end
    chk("t6_wrap", 32'(fetch_cnt), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] npc;
      npc = {$urandom} & 32'hffff_fffc;
      if ($urandom_range(0, 31) == 0) npc[1:0] = 2'($urandom_range(1, 3));
      step(($urandom_range(0, 99) == 0), 1'($urandom), npc, 1'($urandom), 1'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
